// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: redirect, memory request/response and
// core delivery signals between the prefetch queue and its neighbours.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int OCC_W   = 3
);
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;
  logic               inst_valid;
  logic [ADDR_W-1:0]  inst_pc;
  logic [INSTR_W-1:0] inst_data;
  logic               inst_ready;
  logic [OCC_W-1:0]   occupancy;

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  inst_ready,
    output mem_req_valid,
    output mem_req_addr,
    output inst_valid,
    output inst_pc,
    output inst_data,
    output occupancy
  );

  modport master (
    output redirect_valid,
    output redirect_pc,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    output inst_ready,
    input  mem_req_valid,
    input  mem_req_addr,
    input  inst_valid,
    input  inst_pc,
    input  inst_data,
    input  occupancy
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues word fetches, buffers in-order
// responses and hands {pc, instr} to decode; redirects flush and restart.
module fetch_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_prefetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = OCC_W + 4;

  logic [ADDR_W-1:0]  r_pc   [DEPTH];
  logic [INSTR_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]   r_filled;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W-1:0]   r_fptr;
  logic [OCC_W-1:0]   r_occ;
  logic [OCC_W-1:0]   r_npend;
  logic [CNT_W-1:0]   r_discard;
  logic [ADDR_W-1:0]  r_fetch_pc;

  logic               w_full;
  logic               w_alloc;
  logic               w_pop;
  logic               w_fill;
  logic               w_drop;
  logic [CNT_W-1:0]   w_outst;
  logic [CNT_W-1:0]   w_disc_nxt;

  assign w_full = (r_occ == OCC_W'(DEPTH));

  assign bus.mem_req_valid = !reset && !bus.redirect_valid && !w_full;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign bus.inst_valid    = !reset && r_filled[r_head];
  assign bus.inst_pc       = r_pc[r_head];
  assign bus.inst_data     = r_data[r_head];
  assign bus.occupancy     = r_occ;

  assign w_alloc = bus.mem_req_valid && bus.mem_req_ready;
  assign w_pop   = bus.inst_valid && bus.inst_ready;
  assign w_drop  = bus.mem_rsp_valid && (r_discard != '0);
  assign w_fill  = bus.mem_rsp_valid && (r_discard == '0)
                && (r_npend != '0);

  // In flight = live pending entries plus already-orphaned requests;
  // a response landing in the redirect cycle is one of them.
  assign w_outst    = r_discard + CNT_W'(r_npend);
  assign w_disc_nxt = w_outst
                    - CNT_W'(bus.mem_rsp_valid && (w_outst != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
      r_filled   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fptr     <= '0;
      r_occ      <= '0;
      r_npend    <= '0;
      r_discard  <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_filled   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fptr     <= '0;
      r_occ      <= '0;
      r_npend    <= '0;
      r_discard  <= w_disc_nxt;
      r_fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    end else begin
      if (w_alloc) begin
        r_pc[r_tail] <= r_fetch_pc;
        r_tail       <= r_tail + 1'b1;
        r_fetch_pc   <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_fill) begin
        r_data[r_fptr]   <= bus.mem_rsp_data;
        r_filled[r_fptr] <= 1'b1;
        r_fptr           <= r_fptr + 1'b1;
      end
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      if (w_drop)
        r_discard <= r_discard - 1'b1;
      r_occ   <= r_occ + OCC_W'(w_alloc) - OCC_W'(w_pop);
      r_npend <= r_npend + OCC_W'(w_alloc) - OCC_W'(w_fill);
    end
  end
endmodule
